// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and the stall/flush sequencer.
// The datapath side (master) presents the ID/EX instruction words, the EX branch
// outcome and the resume pulse; the sequencer side (slave) returns the enables,
// flushes, halted flag and its state encoding.
interface pipeline_ctrl_if;
  logic [15:0] instruction_ID;
  logic [15:0] instruction_EX;
  logic        branch_taken_EX;
  logic        resume;
  logic        pc_enable;
  logic        if_id_enable;
  logic        if_id_flush;
  logic        id_ex_enable;
  logic        id_ex_flush;
  logic        ex_mem_bubble;
  logic        halted;
  logic [2:0]  ctrl_state;

  modport master (
    output instruction_ID, instruction_EX, branch_taken_EX, resume,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
           ex_mem_bubble, halted, ctrl_state
  );

  modport slave (
    input  instruction_ID, instruction_EX, branch_taken_EX, resume,
    output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
           ex_mem_bubble, halted, ctrl_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 4-stage 16-bit pipeline (IF, ID, EX, MEM).
// Handles load-use stalls, taken-branch flushes, multi-cycle MUL/DIV occupancy
// of EX and the HALT/resume sequence. Hazards are answered combinationally in
// the cycle they are presented; only the state and MUL/DIV countdown are stored.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_ctrl #(
  parameter logic [3:0]  LOAD_OP       = 4'hB,
  parameter logic [3:0]  MULDIV_OP     = 4'hC,
  parameter logic [3:0]  HALT_OP       = 4'hF,
  parameter int unsigned MULDIV_CYCLES = 4
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W        = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_ctrl_if.slave       bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    stall_cycles,
  output logic [PERF_W-1:0]    flush_events
`endif
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_STALL = 3'd1,
    MD_BUSY  = 3'd2,
    HALTED   = 3'd3
  } ctrl_state_e;

  // A single-cycle MUL/DIV never occupies EX beyond its own cycle.
  localparam bit         MD_MULTI = (MULDIV_CYCLES > 1);
  localparam logic [3:0] MD_LOAD  = MD_MULTI ? 4'(MULDIV_CYCLES - 2) : 4'd0;

  ctrl_state_e state, state_next;
  logic [3:0]  md_cnt, md_cnt_next;

  logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_bub, halt_o;
  logic branch_flush;

  logic [3:0] ex_op, ex_rd, id_op, id_rs1, id_rs2;
  logic       load_use;

  assign ex_op  = bus.instruction_EX[15:12];
  assign ex_rd  = bus.instruction_EX[11:8];
  assign id_op  = bus.instruction_ID[15:12];
  assign id_rs1 = bus.instruction_ID[11:8];
  assign id_rs2 = bus.instruction_ID[7:4];

  assign load_use = (ex_op == LOAD_OP) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Low bits of both words carry fields this sequencer never inspects.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.instruction_ID[3:0], bus.instruction_EX[7:0]};

  // Next-state and output decode; reset and unknown states force the NOP pattern.
  always_comb begin
    state_next   = state;
    md_cnt_next  = md_cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_fl     = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_fl     = 1'b0;
    ex_bub       = 1'b0;
    halt_o       = 1'b0;
    branch_flush = 1'b0;

    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_fl    = 1'b1;
      id_ex_fl    = 1'b1;
      ex_bub      = 1'b1;
      state_next  = RUN;
      md_cnt_next = '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.branch_taken_EX) begin
            if_id_fl     = 1'b1;
            id_ex_fl     = 1'b1;
            branch_flush = 1'b1;
          end else if (MD_MULTI && (ex_op == MULDIV_OP)) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_bub      = 1'b1;
            state_next  = MD_BUSY;
            md_cnt_next = MD_LOAD;
          end else if (load_use) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_fl   = 1'b1;
            state_next = LD_STALL;
          end else if (id_op == HALT_OP) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_fl   = 1'b1;
            state_next = HALTED;
          end
        end
        LD_STALL: begin
          state_next = RUN;
        end
        MD_BUSY: begin
          if (md_cnt != '0) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_bub      = 1'b1;
            md_cnt_next = md_cnt - 4'd1;
          end else begin
            state_next = RUN;
          end
        end
        HALTED: begin
          if (bus.resume) begin
            if_id_fl   = 1'b1;
            id_ex_fl   = 1'b1;
            state_next = RUN;
          end else begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_fl = 1'b1;
            halt_o   = 1'b1;
          end
        end
        default: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          if_id_fl    = 1'b1;
          id_ex_fl    = 1'b1;
          ex_bub      = 1'b1;
          state_next  = RUN;
          md_cnt_next = '0;
        end
      endcase
    end
  end

  // State and MUL/DIV countdown registers (reset folded into next-state decode).
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  assign bus.pc_enable     = pc_en;
  assign bus.if_id_enable  = if_id_en;
  assign bus.if_id_flush   = if_id_fl;
  assign bus.id_ex_enable  = id_ex_en;
  assign bus.id_ex_flush   = id_ex_fl;
  assign bus.ex_mem_bubble = ex_bub;
  assign bus.halted        = halt_o;
  assign bus.ctrl_state    = state;

`ifdef PIPE_PERF_CNT_EN
  // Saturating counters of stalled cycles and RUN-state branch flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (branch_flush && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = branch_flush;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: load-use, branch flush, MUL/DIV occupancy,
// HALT/resume and reset aborts. Optional counters checked with PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic reset;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_events;
  logic [1:0]  stall_w2, flush_w2;
  pipeline_ctrl_if bus2 ();
  assign bus2.instruction_ID  = bus.instruction_ID;
  assign bus2.instruction_EX  = bus.instruction_EX;
  assign bus2.branch_taken_EX = bus.branch_taken_EX;
  assign bus2.resume          = bus.resume;

  pipeline_ctrl #(.MULDIV_CYCLES(4), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  pipeline_ctrl #(.MULDIV_CYCLES(4), .PERF_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .stall_cycles(stall_w2), .flush_events(flush_w2)
  );
`else
  pipeline_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  // Output bits: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, bubble, halted}
  localparam logic [6:0] O_DEF = 7'b1101000;
  localparam logic [6:0] O_RST = 7'b0010110;
  localparam logic [6:0] O_LDS = 7'b0001100;
  localparam logic [6:0] O_BR  = 7'b1111100;
  localparam logic [6:0] O_MD  = 7'b0000010;
  localparam logic [6:0] O_HLT = 7'b0001101;

  function automatic logic [9:0] observed();
    return {bus.ctrl_state, bus.pc_enable, bus.if_id_enable, bus.if_id_flush,
            bus.id_ex_enable, bus.id_ex_flush, bus.ex_mem_bubble, bus.halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [6:0] o);
    check(tag, 32'(observed()), 32'({st, o}));
  endtask

  // Advance one clock, then apply new inputs just after the edge.
  task automatic cyc(input logic rst, input logic [15:0] id, input logic [15:0] ex,
                     input logic br, input logic res);
    @(posedge clk);
    #1;
    reset               = rst;
    bus.instruction_ID  = id;
    bus.instruction_EX  = ex;
    bus.branch_taken_EX = br;
    bus.resume          = res;
    #1;
  endtask

  int unsigned stalls;

  initial begin
    reset = 1'b1;
    bus.instruction_ID = '0; bus.instruction_EX = '0;
    bus.branch_taken_EX = 1'b0; bus.resume = 1'b0;

    // Reset
    cyc(1, 16'h0000, 16'h0000, 0, 0);
    chk_out("reset_outputs", 3'd0, O_RST);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("run_default", 3'd0, O_DEF);

    // T1 load-use on rs2
    cyc(0, 16'h1430, 16'hB300, 0, 0);
    chk_out("ld_use_stall", 3'd0, O_LDS);
    cyc(0, 16'h1430, 16'hB300, 0, 0);
    chk_out("ld_stall_state", 3'd1, O_DEF);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("ld_back_run", 3'd0, O_DEF);

    // T2 branch beats HALT in ID and load-use
    cyc(0, 16'hF000, 16'hB000, 1, 0);
    chk_out("branch_flush", 3'd0, O_BR);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("branch_no_halt", 3'd0, O_DEF);
`ifdef PIPE_PERF_CNT_EN
    check("flush_events_1", 32'(flush_events), 32'd1);
`endif

    // T3 single MUL/DIV, branch ignored while busy
    cyc(0, 16'h0000, 16'hC123, 0, 0);
    chk_out("md_c0", 3'd0, O_MD);
    cyc(0, 16'h0000, 16'hC123, 1, 0);
    chk_out("md_c1_br_ignored", 3'd2, O_MD);
    cyc(0, 16'h0000, 16'hC123, 0, 0);
    chk_out("md_c2", 3'd2, O_MD);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("md_c3_release", 3'd2, O_DEF);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("md_back_run", 3'd0, O_DEF);
`ifdef PIPE_PERF_CNT_EN
    check("stall_cycles_4", 32'(stall_cycles), 32'd4);
`endif

    // Load-use on rs1, then a non-matching source
    cyc(0, 16'h1300, 16'hB300, 0, 0);
    chk_out("ld_use_rs1", 3'd0, O_LDS);
    cyc(0, 16'h1450, 16'hB300, 0, 0);
    chk_out("ld_stall_no_redetect", 3'd1, O_DEF);
    cyc(0, 16'h1450, 16'hB300, 0, 0);
    chk_out("ld_no_match", 3'd0, O_DEF);

    // Back-to-back MUL/DIV: 6 stall cycles in 8
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 16'h0000, (i < 7) ? 16'hC123 : 16'h0000, 0, 0);
      if (!bus.pc_enable) stalls++;
    end
    check("md_b2b_stalls", stalls, 32'd6);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("md_b2b_run", 3'd0, O_DEF);

    // Resume outside HALTED is ignored
    cyc(0, 16'h0000, 16'h0000, 0, 1);
    chk_out("resume_ignored", 3'd0, O_DEF);

    // T4 halt, hold 10 cycles, resume
    cyc(0, 16'hF000, 16'h0000, 0, 0);
    chk_out("halt_entry", 3'd0, O_LDS);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 16'hF000, 16'h0000, 0, 0);
      chk_out("halt_hold", 3'd3, O_HLT);
    end
    cyc(0, 16'hF000, 16'h0000, 0, 1);
    chk_out("resume_pulse", 3'd3, O_BR);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("resume_run", 3'd0, O_DEF);

    // T5 reset with md_cnt=1
    cyc(0, 16'h0000, 16'hC123, 0, 0);
    cyc(0, 16'h0000, 16'hC123, 0, 0);
    cyc(1, 16'h0000, 16'hC123, 0, 0);
    chk_out("reset_in_md", 3'd2, O_RST);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("reset_md_run", 3'd0, O_DEF);

    // Reset while HALTED
    cyc(0, 16'hF000, 16'h0000, 0, 0);
    cyc(0, 16'hF000, 16'h0000, 0, 0);
    chk_out("halted_pre_reset", 3'd3, O_HLT);
    cyc(1, 16'hF000, 16'h0000, 0, 0);
    chk_out("reset_in_halt", 3'd3, O_RST);
    cyc(0, 16'h0000, 16'h0000, 0, 0);
    chk_out("reset_halt_run", 3'd0, O_DEF);

`ifdef PIPE_PERF_CNT_EN
    // Five load-use stalls: wide counter reaches 5, 2-bit copy saturates at 3
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h1300, 16'hB300, 0, 0);
      cyc(0, 16'h0000, 16'h0000, 0, 0);
    end
    check("stall_cycles_5", 32'(stall_cycles), 32'd5);
    check("stall_w2_sat", 32'(stall_w2), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
